// File: rtl/pc_sequencer.sv
// Program-counter sequencer: stall, branch, jump, jump-register, exception redirect with EPC
// capture, and a circular return-address stack for call/return.
module pc_sequencer #(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(32'h0000_0020),
  parameter int                RAS_DEPTH  = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     stall,
  input  logic                     sign_jump,
  input  logic [ADDR_W-1:0]        jump_address,
  input  logic                     select_branch,
  input  logic signed [ADDR_W-1:0] extended_immediate,
  input  logic                     jump_reg,
  input  logic [ADDR_W-1:0]        reg_address,
  input  logic                     call,
  input  logic                     ret,
  input  logic                     exception,
  output logic [ADDR_W-1:0]        PC,
  output logic [ADDR_W-1:0]        epc,
  output logic                     ras_empty,
  output logic                     ras_full,
  output logic                     ras_error
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    SRC_SEQ,
    SRC_BRANCH,
    SRC_JUMP,
    SRC_JREG,
    SRC_RET,
    SRC_HOLD,
    SRC_EXC
  } src_e;

  src_e              src;
  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  top_ptr;
  logic [PTR_W-1:0]  push_ptr;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] pc_branch;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] ras_top;
  logic              do_push;
  logic              do_pop;
  logic              underflow;
  logic              overflow;

  // Next-PC source selection, highest priority first.
  always_comb begin
    src = SRC_SEQ;
    if (exception)          src = SRC_EXC;
    else if (stall)         src = SRC_HOLD;
    else if (ret)           src = SRC_RET;
    else if (jump_reg)      src = SRC_JREG;
    else if (sign_jump)     src = SRC_JUMP;
    else if (select_branch) src = SRC_BRANCH;
  end

  assign pc_inc    = PC + ADDR_W'(1);
  assign pc_branch = pc_inc + extended_immediate;
  assign ras_top   = ras_mem[top_ptr];
  assign push_ptr  = top_ptr + PTR_W'(1);

  assign ras_empty = (count == '0);
  assign ras_full  = (count == CNT_W'(RAS_DEPTH));

  // Only absolute and register jumps can be calls; a return never pushes.
  assign do_push   = call && ((src == SRC_JUMP) || (src == SRC_JREG));
  assign do_pop    = (src == SRC_RET) && !ras_empty;
  assign underflow = (src == SRC_RET) && ras_empty;
  assign overflow  = do_push && ras_full;

  always_comb begin
    pc_next = pc_inc;
    case (src)
      SRC_EXC:    pc_next = EXC_VECTOR;
      SRC_HOLD:   pc_next = PC;
      SRC_RET:    pc_next = do_pop ? ras_top : reg_address;
      SRC_JREG:   pc_next = reg_address;
      SRC_JUMP:   pc_next = jump_address;
      SRC_BRANCH: pc_next = pc_branch;
      default:    pc_next = pc_inc;
    endcase
  end

  // Control state: PC, EPC, stack pointer/count and sticky error.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      PC        <= RESET_PC;
      epc       <= '0;
      count     <= '0;
      top_ptr   <= '0;
      ras_error <= 1'b0;
    end else begin
      PC <= pc_next;
      if (src == SRC_EXC) begin
        epc   <= PC;
        count <= '0;
      end else if (do_push) begin
        // A full stack wraps the top pointer onto the oldest entry.
        top_ptr <= push_ptr;
        if (!ras_full) count <= count + CNT_W'(1);
      end else if (do_pop) begin
        top_ptr <= top_ptr - PTR_W'(1);
        count   <= count - CNT_W'(1);
      end
      if (overflow || underflow) ras_error <= 1'b1;
    end
  end

  // Stack storage is data only; entries are meaningless while count is zero.
  always_ff @(posedge clock) begin
    if (do_push) ras_mem[push_ptr] <= pc_inc;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: queue-based reference model compared every cycle,
// plus literal expectations at key points of each scenario.
module tb_pc_sequencer;

  logic               clock = 1'b0;
  logic               reset_n;
  logic               stall, sign_jump, select_branch, jump_reg, call, ret, exception;
  logic [31:0]        jump_address, reg_address;
  logic signed [31:0] extended_immediate;
  logic [31:0]        PC, epc;
  logic               ras_empty, ras_full, ras_error;

  pc_sequencer dut (
    .clock(clock), .reset_n(reset_n), .stall(stall), .sign_jump(sign_jump),
    .jump_address(jump_address), .select_branch(select_branch),
    .extended_immediate(extended_immediate), .jump_reg(jump_reg),
    .reg_address(reg_address), .call(call), .ret(ret), .exception(exception),
    .PC(PC), .epc(epc), .ras_empty(ras_empty), .ras_full(ras_full), .ras_error(ras_error)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  bit check_en = 1'b0;

  logic [31:0] m_pc, m_epc;
  logic        m_err;
  logic [31:0] m_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'd0;
    m_epc = 32'd0;
    m_err = 1'b0;
    m_q.delete();
  endtask

  task automatic model_step();
    logic [31:0] nxt;
    if (!reset_n) return;
    nxt = m_pc + 32'd1;
    if (exception) begin
      m_epc = m_pc;
      m_pc = 32'h20;
      m_q.delete();
    end else if (!stall) begin
      if (ret) begin
        if (m_q.size() > 0) m_pc = m_q.pop_back();
        else begin
          m_pc = reg_address;
          m_err = 1'b1;
        end
      end else if (jump_reg || sign_jump) begin
        if (call) begin
          if (m_q.size() == 4) begin
            void'(m_q.pop_front());
            m_err = 1'b1;
          end
          m_q.push_back(nxt);
        end
        m_pc = jump_reg ? reg_address : jump_address;
      end else if (select_branch) begin
        m_pc = nxt + extended_immediate;
      end else begin
        m_pc = nxt;
      end
    end
  endtask

  task automatic clear_inputs();
    stall = 0; sign_jump = 0; select_branch = 0; jump_reg = 0;
    call = 0; ret = 0; exception = 0;
    jump_address = '0; reg_address = '0; extended_immediate = '0;
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    @(negedge clock);
    clear_inputs();
  endtask

  always @(negedge clock) begin
    if (check_en) begin
      chk("pc", PC, m_pc);
      chk("epc", epc, m_epc);
      chk("ras_empty", {31'd0, ras_empty}, {31'd0, m_q.size() == 0});
      chk("ras_full", {31'd0, ras_full}, {31'd0, m_q.size() == 4});
      chk("ras_error", {31'd0, ras_error}, {31'd0, m_err});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    reset_n = 1'b1;
    model_reset();
    #1 reset_n = 1'b0;
    check_en = 1'b1;
    repeat (2) @(negedge clock);
    chk("reset_pc", PC, 32'd0);
    chk("reset_epc", epc, 32'd0);
    chk("reset_empty", {31'd0, ras_empty}, 32'd1);
    chk("reset_full", {31'd0, ras_full}, 32'd0);
    chk("reset_err", {31'd0, ras_error}, 32'd0);
    reset_n = 1'b1;

    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("seq_pc", PC, 32'(i));
    end

    sign_jump = 1; jump_address = 32'd10; tick();
    select_branch = 1; extended_immediate = -32'sd3; tick();
    chk("branch_back", PC, 32'd8);
    sign_jump = 1; jump_address = 32'd10; tick();
    sign_jump = 1; select_branch = 1; jump_address = 32'd100; extended_immediate = 32'sd5; tick();
    chk("jump_over_branch", PC, 32'd100);

    sign_jump = 1; jump_address = 32'd5; tick();
    sign_jump = 1; call = 1; jump_address = 32'd40; tick();
    chk("call_pc", PC, 32'd40);
    chk("call_not_empty", {31'd0, ras_empty}, 32'd0);
    chk("model_top", m_q[$], 32'd6);
    tick();
    ret = 1; tick();
    chk("ret_pc", PC, 32'd6);
    chk("ret_empty", {31'd0, ras_empty}, 32'd1);

    for (int k = 1; k <= 5; k++) begin
      jump_reg = 1; call = 1; reg_address = 32'(k * 100); tick();
      if (k == 4) begin
        chk("full_4", {31'd0, ras_full}, 32'd1);
        chk("no_err_4", {31'd0, ras_error}, 32'd0);
      end
    end
    chk("full_5", {31'd0, ras_full}, 32'd1);
    chk("overflow_err", {31'd0, ras_error}, 32'd1);
    ret = 1; tick(); chk("pop1", PC, 32'd401);
    ret = 1; tick(); chk("pop2", PC, 32'd301);
    ret = 1; tick(); chk("pop3", PC, 32'd201);
    ret = 1; tick(); chk("pop4", PC, 32'd101);
    ret = 1; reg_address = 32'd77; tick();
    chk("ret_empty_pc", PC, 32'd77);
    chk("ret_empty_flag", {31'd0, ras_empty}, 32'd1);

    stall = 1; sign_jump = 1; jump_address = 32'd999; tick();
    chk("stall_hold", PC, 32'd77);
    sign_jump = 1; call = 1; jump_address = 32'd12; tick();
    chk("pc_12", PC, 32'd12);
    stall = 1; exception = 1; sign_jump = 1; tick();
    chk("exc_pc", PC, 32'h20);
    chk("exc_epc", epc, 32'd12);
    chk("exc_flush", {31'd0, ras_empty}, 32'd1);
    stall = 1; jump_reg = 1; call = 1; reg_address = 32'd3; tick();
    chk("stall_call_pc", PC, 32'h20);
    chk("stall_no_push", {31'd0, ras_empty}, 32'd1);
    select_branch = 1; call = 1; extended_immediate = 32'sd4; tick();
    chk("branch_call_pc", PC, 32'h25);
    chk("branch_no_push", {31'd0, ras_empty}, 32'd1);
    ret = 1; jump_reg = 1; call = 1; reg_address = 32'd60; tick();
    chk("ret_call_pc", PC, 32'd60);

    sign_jump = 1; jump_address = 32'hFFFF_FFFF; tick();
    tick();
    chk("wrap_pc", PC, 32'd0);
    sign_jump = 1; jump_address = 32'hFFFF_FFFE; tick();
    select_branch = 1; extended_immediate = 32'sd2; tick();
    chk("branch_wrap", PC, 32'd1);

    @(posedge clock);
    model_step();
    #1 chk("pre_reset_pc", PC, 32'd2);
    #1 reset_n = 1'b0;
    model_reset();
    #1;
    chk("async_pc", PC, 32'd0);
    chk("async_epc", epc, 32'd0);
    chk("async_err", {31'd0, ras_error}, 32'd0);
    chk("async_empty", {31'd0, ras_empty}, 32'd1);
    @(negedge clock);
    reset_n = 1'b1;

    ret = 1; reg_address = 32'd55; tick();
    chk("underflow_pc", PC, 32'd55);
    chk("underflow_err", {31'd0, ras_error}, 32'd1);

    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
